// File: rtl/audioqsys_switch_debounce_ctrl.sv
// Avalon-MM slave for the board slide switches: 2-flop synchroniser, tick-sampled debounce, DATA/CTRL regs.
// Define SWITCH_DEBOUNCE_IRQ_EN to build MASK/EDGE registers, CTRL.RISE and the interrupt.
module audioqsys_switch_debounce_ctrl #(
  parameter int WIDTH           = 18,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1, r_sync2;
  logic [WIDTH-1:0] r_hist1, r_hist0;
  logic [WIDTH-1:0] r_deb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_en;
  logic [31:0]      r_readdata;

  logic             w_tick;
  logic [WIDTH-1:0] w_agree;
  logic [WIDTH-1:0] w_deb_next;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_unused = ^writedata;

  assign w_tick     = r_en && (r_cnt == LP_CNT_MAX);
  // A bit only moves when the two stored samples and the current one all agree.
  assign w_agree    = ~(r_hist1 ^ r_hist0) & ~(r_hist0 ^ r_sync2);
  assign w_deb_next = w_tick ? ((w_agree & r_sync2) | (~w_agree & r_deb)) : r_deb;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!r_en || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_hist1 <= '0;
      r_hist0 <= '0;
      r_deb   <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
      if (w_tick) begin
        r_hist1 <= r_hist0;
        r_hist0 <= r_sync2;
        r_deb   <= w_deb_next;
      end
    end
  end

`ifdef SWITCH_DEBOUNCE_IRQ_EN
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic             r_rise;
  logic [WIDTH-1:0] w_chg;
  logic [WIDTH-1:0] w_edge_new;
  logic [WIDTH-1:0] w_clr;

  assign w_chg      = w_deb_next ^ r_deb;
  assign w_edge_new = r_rise ? (w_chg & w_deb_next) : w_chg;
  assign w_clr      = (write && address == 2'd2) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en   <= 1'b1;
      r_rise <= 1'b0;
      r_mask <= '0;
      r_edge <= '0;
    end else begin
      if (write && address == 2'd3) begin
        r_en   <= writedata[0];
        r_rise <= writedata[1];
      end
      if (write && address == 2'd1) begin
        r_mask <= writedata[WIDTH-1:0];
      end
      // New edges are OR-ed in after the clear so a simultaneous set wins.
      r_edge <= (r_edge & ~w_clr) | w_edge_new;
    end
  end

  assign irq = |(r_edge & r_mask);

  always_comb begin
    w_rdata = '0;
    case (address)
      2'd0:    w_rdata[WIDTH-1:0] = r_deb;
      2'd1:    w_rdata[WIDTH-1:0] = r_mask;
      2'd2:    w_rdata[WIDTH-1:0] = r_edge;
      default: w_rdata[1:0]       = {r_rise, r_en};
    endcase
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en <= 1'b1;
    end else if (write && address == 2'd3) begin
      r_en <= writedata[0];
    end
  end

  assign irq = 1'b0;

  always_comb begin
    w_rdata = '0;
    case (address)
      2'd0:    w_rdata[WIDTH-1:0] = r_deb;
      2'd3:    w_rdata[0]         = r_en;
      default: w_rdata            = '0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rdata;
    end
  end

  assign readdata = r_readdata;

endmodule

// File: tb/tb_audioqsys_switch_debounce_ctrl.sv
// Directed bench for audioqsys_switch_debounce_ctrl with DEBOUNCE_CYCLES=4 (tick every 4th clk edge).
module tb_audioqsys_switch_debounce_ctrl;

`ifdef SWITCH_DEBOUNCE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] in_port;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [31:0] rd_val;

  audioqsys_switch_debounce_ctrl #(
    .WIDTH(18),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_port(in_port),
    .address(address),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Edge count since reset release; with EN held at 1 the DUT ticks when this is a multiple of 4.
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write     = 1'b0;
  endtask

  task automatic align();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cyc % 4 == 0) break;
    end
  endtask

  task automatic settle();
    repeat (20) @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    in_port   = '0;
    address   = '0;
    write     = 1'b0;
    writedata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    rd(2'd0, rd_val); check("rst_data", rd_val, 32'h0);
    rd(2'd1, rd_val); check("rst_mask", rd_val, 32'h0);
    rd(2'd2, rd_val); check("rst_edge", rd_val, 32'h0);
    rd(2'd3, rd_val); check("rst_ctrl", rd_val, 32'h1);
    check("rst_irq", {31'b0, irq}, 32'h0);

    // Steady input: deb updates on the third tick after the change
    wr(2'd1, 32'h0003_FFFF);
    rd(2'd1, rd_val); check("mask_rb", rd_val, IRQ_EN ? 32'h0003_FFFF : 32'h0);
    address = 2'd0;
    align();
    in_port = 18'h00005;
    repeat (11) @(negedge clk);
    check("steady_irq_pre", {31'b0, irq}, 32'h0);
    check("steady_data_pre2", readdata, 32'h0);
    @(negedge clk);
    check("steady_data_pre1", readdata, 32'h0);
    check("steady_irq_set", {31'b0, irq}, IRQ_EN ? 32'h1 : 32'h0);
    @(negedge clk);
    check("steady_data", readdata, 32'h0000_0005);
    rd(2'd2, rd_val); check("steady_edge", rd_val, IRQ_EN ? 32'h5 : 32'h0);
    wr(2'd2, 32'hFFFF_FFFF);
    check("w1c_irq_drop", {31'b0, irq}, 32'h0);
    rd(2'd2, rd_val); check("w1c_edge", rd_val, 32'h0);

    // Bounce: bit 0 alternates every tick and must never be accepted
    address = 2'd0;
    align();
    for (int i = 0; i < 8; i++) begin
      in_port[0] = i[0];
      repeat (4) @(negedge clk);
      check("bounce_data", readdata, 32'h0000_0005);
    end
    rd(2'd2, rd_val); check("bounce_edge", rd_val, 32'h0);

    // Rising-only edge capture on bit 3
    in_port = 18'h0000D;
    settle();
    rd(2'd0, rd_val); check("bit3_up_data", rd_val, 32'h0000_000D);
    wr(2'd2, 32'hFFFF_FFFF);
    wr(2'd3, 32'h3);
    rd(2'd3, rd_val); check("ctrl_rise_rb", rd_val, IRQ_EN ? 32'h3 : 32'h1);
    in_port = 18'h00005;
    settle();
    rd(2'd0, rd_val); check("fall_data", rd_val, 32'h0000_0005);
    rd(2'd2, rd_val); check("fall_edge", rd_val, 32'h0);
    in_port = 18'h0000D;
    settle();
    rd(2'd0, rd_val); check("rise_data", rd_val, 32'h0000_000D);
    rd(2'd2, rd_val); check("rise_edge", rd_val, IRQ_EN ? 32'h8 : 32'h0);
    wr(2'd3, 32'h1);

    // W1C on the same edge that captures a new bit-0 change: set wins
    wr(2'd2, 32'hFFFF_FFFF);
    wr(2'd1, 32'h1);
    address = 2'd0;
    align();
    in_port = 18'h0000C;
    repeat (11) @(negedge clk);
    address   = 2'd2;
    writedata = 32'h1;
    write     = 1'b1;
    @(negedge clk);
    write = 1'b0;
    check("setwins_irq", {31'b0, irq}, IRQ_EN ? 32'h1 : 32'h0);
    rd(2'd2, rd_val); check("setwins_edge", rd_val, IRQ_EN ? 32'h1 : 32'h0);
    rd(2'd0, rd_val); check("setwins_data", rd_val, 32'h0000_000C);
    check("setwins_irq_hold", {31'b0, irq}, IRQ_EN ? 32'h1 : 32'h0);
    wr(2'd2, 32'h1);
    check("late_w1c_irq", {31'b0, irq}, 32'h0);

    // EN cleared: debounce frozen; re-enable restarts ticks from count 0
    wr(2'd3, 32'h0);
    rd(2'd3, rd_val); check("ctrl_off_rb", rd_val, 32'h0);
    in_port = 18'h3FFFF;
    address = 2'd0;
    for (int i = 0; i < 10; i++) begin
      repeat (10) @(negedge clk);
      check("en_off_data", readdata, 32'h0000_000C);
    end
    wr(2'd3, 32'h1);
    address = 2'd0;
    repeat (12) @(negedge clk);
    check("en_on_data_pre", readdata, 32'h0000_000C);
    @(negedge clk);
    check("en_on_data", readdata, 32'h0003_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
